// File: rtl/key_disp_scan.sv
// key_disp_scan: six debounced push keys edit a multiplexed
// 7-segment hex display with a blinking cursor digit.
module key_disp_scan #(
  parameter int N_DIG      = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int DB_CYCLES  = 1000000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [5:0]               i_key,
  output logic [5:0]               o_key_state,
  output logic [5:0]               o_key_press,
  output logic [N_DIG-1:0]         o_cs,
  output logic [7:0]               o_dig_sel,
  output logic [$clog2(N_DIG)-1:0] o_cursor,
  output logic [4*N_DIG-1:0]       o_value
);

  localparam int CW  = $clog2(N_DIG);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int SW  = $clog2(SCAN_DIV + 1);
  localparam int BW  = $clog2(BLINK_HALF + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [SW-1:0]  SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0]  BLNK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [CW-1:0]  DIG_LAST  = CW'(N_DIG - 1);

  // Standard active-low hex glyphs, dp bit kept off.
  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic [5:0] sync1;
  logic [5:0] sync2;

  // Two-flop synchronizer; keys are inverted so 1 means pressed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~i_key;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < 6; k++) begin : g_db
    logic [DBW-1:0] cnt;
    logic           st;
    logic           pr;

    // Accept a new level only after DB_CYCLES differing samples;
    // the press pulse is raised on the same edge the level rises.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        cnt <= '0;
        st  <= 1'b0;
        pr  <= 1'b0;
      end else begin
        pr <= 1'b0;
        if (sync2[k] == st) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt <= '0;
          st  <= sync2[k];
          pr  <= sync2[k];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign o_key_state[k] = st;
    assign o_key_press[k] = pr;
  end

  logic [5:0]       act;
  logic [3:0]       nib [N_DIG];
  logic [N_DIG-1:0] dot;
  logic [CW-1:0]    cursor;

  // Reduce coincident presses to the single winning action.
  always_comb begin
    act = 6'b0;
    if (o_key_press[5])      act[5] = 1'b1;
    else if (o_key_press[0]) act[0] = 1'b1;
    else if (o_key_press[1]) act[1] = 1'b1;
    else if (o_key_press[2]) act[2] = 1'b1;
    else if (o_key_press[3]) act[3] = 1'b1;
    else if (o_key_press[4]) act[4] = 1'b1;
  end

  // Edit engine: apply the winning action to nibbles, dots, cursor.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_DIG; i++) nib[i] <= 4'h0;
      dot    <= '0;
      cursor <= '0;
    end else begin
      unique case (1'b1)
        act[5]: begin
          for (int i = 0; i < N_DIG; i++) nib[i] <= 4'h0;
          dot <= '0;
        end
        act[0]: nib[cursor] <= nib[cursor] + 4'h1;
        act[1]: nib[cursor] <= nib[cursor] - 4'h1;
        act[2]: dot[cursor] <= ~dot[cursor];
        act[3]: cursor <= (cursor == DIG_LAST) ? '0
                                               : cursor + 1'b1;
        act[4]: cursor <= (cursor == '0) ? DIG_LAST
                                         : cursor - 1'b1;
        default: ;
      endcase
    end
  end

  logic [SW-1:0] slot;
  logic [CW-1:0] ptr;
  logic          active;

  // Slot timer; the first wrap only enables digit 0,
  // later wraps step the pointer round the digits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      slot   <= '0;
      ptr    <= '0;
      active <= 1'b0;
    end else if (slot == SCAN_LAST) begin
      slot <= '0;
      if (!active) begin
        active <= 1'b1;
      end else begin
        ptr <= (ptr == DIG_LAST) ? '0 : ptr + 1'b1;
      end
    end else begin
      slot <= slot + 1'b1;
    end
  end

  logic [BW-1:0] blink;
  logic          phase;

  // Free-running cursor blink, untouched by edits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      blink <= '0;
      phase <= 1'b1;
    end else if (blink == BLNK_LAST) begin
      blink <= '0;
      phase <= ~phase;
    end else begin
      blink <= blink + 1'b1;
    end
  end

  logic [7:0] glyph;

  always_comb begin
    glyph    = hex7(nib[ptr]);
    glyph[7] = glyph[7] & ~dot[ptr];
  end

  // Registered drive of the digit select and segments.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cs      <= '1;
      o_dig_sel <= 8'hFF;
    end else if (!active) begin
      o_cs      <= '1;
      o_dig_sel <= 8'hFF;
    end else begin
      o_cs <= ~(N_DIG'(1) << ptr);
      if (!phase && ptr == cursor) o_dig_sel <= 8'hFF;
      else                         o_dig_sel <= glyph;
    end
  end

  // Flatten the nibble store for observation.
  always_comb begin
    o_value = '0;
    for (int i = 0; i < N_DIG; i++) o_value[4*i +: 4] = nib[i];
  end

  assign o_cursor = cursor;

endmodule

// File: tb/tb_key_disp_scan.sv
// tb_key_disp_scan: random key stimulus against a sliding-window
// debounce model and a time-based scan/blink model.
module tb_key_disp_scan;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int DB = 8;
  localparam int BH = 64;

  logic        clk;
  logic        rst_n;
  logic [5:0]  key;
  logic [5:0]  o_key_state;
  logic [5:0]  o_key_press;
  logic [3:0]  o_cs;
  logic [7:0]  o_dig_sel;
  logic [1:0]  o_cursor;
  logic [15:0] o_value;

  key_disp_scan #(
    .N_DIG(N), .SCAN_DIV(S), .DB_CYCLES(DB), .BLINK_HALF(BH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_key(key),
    .o_key_state(o_key_state),
    .o_key_press(o_key_press),
    .o_cs(o_cs),
    .o_dig_sel(o_dig_sel),
    .o_cursor(o_cursor),
    .o_value(o_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_print  = 0;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[v];
  endfunction

  // Behavioural model state.
  bit         mv = 0;
  int         c;
  logic [5:0] hist [$];
  logic [5:0] m_db, m_press, np;
  logic [3:0] m_nib [N];
  logic [3:0] m_dot;
  int         m_cur;
  logic [3:0] exp_cs;
  logic [7:0] exp_seg;

  always @(posedge clk) begin
    if (!rst_n) begin
      mv = 1; c = 0; hist.delete();
      m_db = 0; m_press = 0; m_dot = 0; m_cur = 0;
      for (int i = 0; i < N; i++) m_nib[i] = 0;
      exp_cs = 4'hF; exp_seg = 8'hFF;
    end else if (mv) begin
      int w, p;
      bit ph, all;
      w = c / S;
      if (w == 0) begin
        exp_cs = 4'hF; exp_seg = 8'hFF;
      end else begin
        p = (w - 1) % N;
        exp_cs = ~(4'b1 << p);
        ph = ((c / BH) % 2) == 0;
        if (!ph && p == m_cur) exp_seg = 8'hFF;
        else exp_seg = glyph(m_nib[p]) & (m_dot[p] ? 8'h7F : 8'hFF);
      end
      if (m_press[5]) begin
        for (int i = 0; i < N; i++) m_nib[i] = 0;
        m_dot = 0;
      end else if (m_press[0]) m_nib[m_cur] = m_nib[m_cur] + 1;
      else if (m_press[1]) m_nib[m_cur] = m_nib[m_cur] - 1;
      else if (m_press[2]) m_dot[m_cur] = ~m_dot[m_cur];
      else if (m_press[3]) m_cur = (m_cur + 1) % N;
      else if (m_press[4]) m_cur = (m_cur + N - 1) % N;
      hist.push_back(~key);
      while (hist.size() > DB + 2) void'(hist.pop_front());
      np = 0;
      if (hist.size() == DB + 2) begin
        for (int k = 0; k < 6; k++) begin
          all = 1;
          for (int j = 2; j <= DB + 1; j++)
            if (hist[hist.size() - 1 - j][k] == m_db[k]) all = 0;
          if (all) begin
            m_db[k] = ~m_db[k];
            np[k] = m_db[k];
          end
        end
      end
      m_press = np;
      c++;
    end
  end

  // Compare process: every cycle once the model is live.
  always @(negedge clk) begin
    if (mv) begin
      logic [15:0] ev;
      for (int i = 0; i < N; i++) ev[4*i +: 4] = m_nib[i];
      n_checks++;
      if (o_key_state !== m_db || o_key_press !== m_press ||
          o_cs !== exp_cs || o_dig_sel !== exp_seg ||
          o_cursor !== 2'(m_cur) || o_value !== ev) begin
        n_err++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL model t=%0t st=%h/%h pr=%h/%h cs=%h/%h seg=%h/%h cur=%0d/%0d val=%h/%h",
                   $time, o_key_state, m_db, o_key_press, m_press,
                   o_cs, exp_cs, o_dig_sel, exp_seg,
                   o_cursor, m_cur, o_value, ev);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [5:0] m);
    key = ~m;
    tick(12);
    key = 6'h3F;
    tick(12);
  endtask

  logic [3:0] cs_seen [1:24];
  int         found, presses;
  bit         saw_a, saw_b;

  initial begin
    rst_n = 1'b0;
    key   = 6'h3F;
    tick(3);
    chk("rst_cs", 32'(o_cs), 32'hF);
    chk("rst_seg", 32'(o_dig_sel), 32'hFF);
    chk("rst_value", 32'(o_value), 32'h0);
    chk("rst_cursor", 32'(o_cursor), 32'h0);
    chk("rst_key_state", 32'(o_key_state), 32'h0);
    rst_n = 1'b1;

    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      cs_seen[i] = o_cs;
    end
    chk("scan_idle", 32'(cs_seen[4]), 32'hF);
    chk("scan_d0", 32'(cs_seen[5]), 32'hE);
    chk("scan_d0_end", 32'(cs_seen[8]), 32'hE);
    chk("scan_d1", 32'(cs_seen[9]), 32'hD);
    chk("scan_d2", 32'(cs_seen[13]), 32'hB);
    chk("scan_d3", 32'(cs_seen[17]), 32'h7);
    chk("scan_wrap", 32'(cs_seen[21]), 32'hE);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk("scan_rst_mid", 32'(o_cs), 32'hF);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      cs_seen[i] = o_cs;
    end
    chk("scan_restart_idle", 32'(cs_seen[4]), 32'hF);
    chk("scan_restart_d0", 32'(cs_seen[5]), 32'hE);

    key[0] = 1'b0;
    tick(5);
    key[0] = 1'b1;
    presses = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_key_press[0]) presses++;
      if (o_key_state[0]) found = 1;
    end
    chk("glitch_press", presses, 0);
    chk("glitch_state", found, 0);

    key[0] = 1'b0;
    found = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_key_press[0]) presses++;
      if (o_key_state[0] && found == 0) found = i;
    end
    chk("press_latency", found, 10);
    chk("press_count", presses, 1);
    chk("nib0_inc", 32'(o_value[3:0]), 32'h1);
    key[0] = 1'b1;
    tick(14);

    repeat (15) press(6'b000001);
    chk("nib0_wrap", 32'(o_value[3:0]), 32'h0);
    press(6'b000010);
    chk("nib0_dec", 32'(o_value[3:0]), 32'hF);
    saw_a = 0;
    saw_b = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (o_cs == 4'hE && o_dig_sel == 8'h8E) saw_a = 1;
      if (o_cs == 4'hE && o_dig_sel == 8'hFF) saw_b = 1;
    end
    chk("blink_on_F", saw_a, 1);
    chk("blink_off", saw_b, 1);

    press(6'b010000);
    chk("cursor_dec_wrap", 32'(o_cursor), 32'h3);
    press(6'b001000);
    chk("cursor_inc_wrap", 32'(o_cursor), 32'h0);
    press(6'b000100);
    saw_a = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (o_cs == 4'hE && o_dig_sel == 8'h0E) saw_a = 1;
    end
    chk("dot_shown", saw_a, 1);

    press(6'b001000);
    repeat (3) press(6'b000001);
    chk("nib1_set", 32'(o_value), 32'h003F);
    press(6'b100001);
    chk("clear_wins", 32'(o_value), 32'h0);
    saw_a = 0;
    saw_b = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (o_cs == 4'hE && o_dig_sel == 8'hC0) saw_a = 1;
      if (o_cs == 4'hE && o_dig_sel[7] == 1'b0) saw_b = 1;
    end
    chk("clear_glyph", saw_a, 1);
    chk("clear_dot", saw_b, 0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) key = 6'($urandom);
      else key = ~(6'b1 << $urandom_range(0, 5));
      tick($urandom_range(1, 24));
    end
    key = 6'h3F;
    tick(30);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/key_disp_scan.md
KEY_DISP_SCAN -- requirements
Module: key_disp_scan

Interface
REQ-001 Parameter N_DIG, 8, number of multiplexed 7-segment digits, legal range 2..16.
REQ-002 Parameter SCAN_DIV, 50000, clock cycles per digit slot (1 kHz at 50 MHz).
REQ-003 Parameter DB_CYCLES, 1000000, consecutive stable cycles required to accept a key change (20 ms).
REQ-004 Parameter BLINK_HALF, 12500000, clock cycles per cursor blink half-period.
REQ-005 Port i_clk  in  1  sole clock, rising edge.
REQ-006 Port i_rst_n  in  1  reset, synchronous, active-low.
REQ-007 Port i_key  in  6  raw keys, active-low, asynchronous to i_clk.
REQ-008 Port o_key_state  out  6  debounced key level, 1=pressed.
REQ-009 Port o_key_press  out  6  one-cycle pulse per accepted press.
REQ-010 Port o_cs  out  N_DIG  digit select, one-hot active-low.
REQ-011 Port o_dig_sel  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-012 Port o_cursor  out  $clog2(N_DIG)  index of the digit being edited.
REQ-013 Port o_value  out  4*N_DIG  digit nibbles, digit k at bits [4k+3:4k].

Function
REQ-014 Each i_key bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-015 Per key, a counter SHALL clear whenever the synchronized value equals the debounced value.
REQ-016 While the values differ, the counter SHALL increment; on the cycle it reaches DB_CYCLES-1, the debounced value SHALL take the synchronized value and the counter SHALL clear.
REQ-017 A clean input edge SHALL appear on o_key_state exactly 2+DB_CYCLES cycles later; a glitch shorter than DB_CYCLES cycles SHALL produce no change.
REQ-018 o_key_press[k] SHALL be high for exactly the cycle in which o_key_state[k] first reads 1; a release SHALL produce no pulse.
REQ-019 Press actions: key0 = cursor nibble +1 mod 16; key1 = cursor nibble -1 mod 16; key2 = toggle cursor dot; key3 = cursor +1, wrapping N_DIG-1 -> 0; key4 = cursor -1, wrapping 0 -> N_DIG-1; key5 = clear all nibbles and dots (cursor unchanged).
REQ-020 Action results SHALL be visible on o_value/o_cursor the cycle after the press pulse.
REQ-021 When several press pulses coincide, only the highest-priority action SHALL execute (key5 > key0 > key1 > key2 > key3 > key4); the others SHALL be dropped.
REQ-022 A slot counter SHALL wrap every SCAN_DIV cycles; on wrap the scan pointer SHALL advance 0,1,...,N_DIG-1,0.
REQ-023 o_cs and o_dig_sel SHALL be registered and reflect the pointer one cycle after it changes; o_cs bit [pointer] SHALL be 0 and all other bits 1.
REQ-024 Segment code SHALL be standard hex 0-F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E. A set dot SHALL clear bit 7.
REQ-025 A blink counter SHALL toggle a phase bit every BLINK_HALF cycles; while the phase is 0 and pointer==cursor, o_dig_sel SHALL be 8'hFF and o_cs SHALL still select the digit.
REQ-026 Edits SHALL not disturb the scan or blink counters.

Reset
REQ-027 With i_rst_n low at a rising edge, the following SHALL be set on that edge: synchronizers and debounced state to released; o_key_state=0; o_key_press=0; all counters=0; pointer=0; cursor=0; nibbles and dots=0; blink phase=1; o_cs all 1s; o_dig_sel=8'hFF.
REQ-028 Reset asserted mid-debounce, mid-slot or mid-press SHALL abandon the operation with no pending action after release.
REQ-029 The first digit SHALL be selected on the first slot wrap after reset release.

Verification (N_DIG=4, SCAN_DIV=4, DB_CYCLES=8, BLINK_HALF=64)
REQ-030 Hold i_rst_n=0 for 3 cycles -> o_cs=4'hF, o_dig_sel=8'hFF, o_value=0, o_cursor=0, o_key_state=0.
REQ-031 Pulse i_key[0] low for 5 cycles -> no o_key_press; hold it low -> o_key_state[0]=1 exactly 10 cycles after the fall, one press pulse, o_value[3:0]=1.
REQ-032 16 key0 presses -> nibble 0 returns to 0; one key1 press -> 4'hF; the digit-0 slot during blink phase 1 shows 8'h8E, and during phase 0 shows 8'hFF.
REQ-033 key4 press at cursor 0 -> o_cursor=3; key3 press -> o_cursor=0; key2 press -> digit 0 shows dp bit cleared.
REQ-034 After setting nibbles, press pulses for key0 and key5 in the same cycle -> o_value=0, dots cleared, no increment applied.
REQ-035 Free-run from reset -> o_cs cycles 1110,1101,1011,0111, each for 4 cycles; assert reset mid-slot -> o_cs=4'hF on that edge and the sequence restarts at 1110.
